// File: rtl/frame_read_timing_gen.sv
// frame_read_timing_gen
//   Self-timed display read engine. Generates its own H/V raster timing,
//   fetches block-packed pixel words (BLK_W x BLK_H pixels per word) from
//   frame memory with a fixed read latency, and emits a registered
//   hsync/vsync/de/data pixel stream. It also provides a test-pattern mode.
//   Timing configuration and pattern select are shadowed once per frame.
//   Start and stop happen only on frame boundaries.
//
// Ports
//   i_clk, rst_n          clock, asynchronous active-low reset
//   i_en                  run enable, sampled at IDLE and on the last VFP cycle
//   i_pat_en              1 = test pattern, 0 = memory data
//   i_hres, i_vres        active pixels / active lines
//   i_hfp,i_hbp,i_vfp,i_vbp  porch lengths (clocks / lines)
//   i_hpulse, i_vpulse    sync widths (clocks / lines)
//   o_ren, o_raddr        memory read request, word address
//   i_rdata               read data, valid RD_LAT cycles after o_ren
//   o_vsync,o_hsync,o_de  registered timing, active high
//   o_data                registered pixel, 0 outside active video
//   o_frame_start         one-cycle pulse on the first VPULSE cycle
module frame_read_timing_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int BLK_W      = 2,
  parameter int BLK_H      = 2,
  parameter int MEM_WIDTH  = DATA_WIDTH*BLK_W*BLK_H,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_pat_en,
  input  logic [10:0]           i_hres,
  input  logic [10:0]           i_vres,
  input  logic [9:0]            i_hfp,
  input  logic [9:0]            i_hbp,
  input  logic [9:0]            i_vfp,
  input  logic [9:0]            i_vbp,
  input  logic [3:0]            i_hpulse,
  input  logic [3:0]            i_vpulse,
  output logic                  o_ren,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [MEM_WIDTH-1:0]  i_rdata,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_frame_start
);

  // shared encoding for the H and V state machines
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PULSE = 3'd1;
  localparam logic [2:0] ST_BP    = 3'd2;
  localparam logic [2:0] ST_ACT   = 3'd3;
  localparam logic [2:0] ST_FP    = 3'd4;

  localparam int          NPX    = BLK_W*BLK_H;
  localparam int          AW2    = ADDR_WIDTH + 2;
  localparam int          LOG_BW = $clog2(BLK_W);
  localparam int          LOG_BH = $clog2(BLK_H);
  localparam logic [11:0] BW_M   = 12'(BLK_W - 1);
  localparam logic [11:0] BH_M   = 12'(BLK_H - 1);

  logic [2:0]  hstate, vstate;
  logic [11:0] col_cnt, row_cnt;
  logic [7:0]  frame_cnt;

  // per-frame shadow copy of the configuration, zero-extended to 12 bits
  logic [11:0] sh_hres, sh_vres, sh_hfp, sh_hbp, sh_vfp, sh_vbp;
  logic [11:0] sh_hpulse, sh_vpulse;
  logic        sh_pat;

  logic [MEM_WIDTH-1:0] word_q;

  // ---------------------------------------------------------------
  // state lengths and boundary events
  // ---------------------------------------------------------------
  logic [11:0] h_len, v_len;
  logic        h_last, v_last, line_end, frame_end;
  logic        start, stop, new_frame;

  always_comb begin
    h_len = 12'd1;
    case (hstate)
      ST_PULSE: h_len = sh_hpulse;
      ST_BP:    h_len = sh_hbp;
      ST_ACT:   h_len = sh_hres;
      ST_FP:    h_len = sh_hfp;
      default:  h_len = 12'd1;
    endcase
  end

  always_comb begin
    v_len = 12'd1;
    case (vstate)
      ST_PULSE: v_len = sh_vpulse;
      ST_BP:    v_len = sh_vbp;
      ST_ACT:   v_len = sh_vres;
      ST_FP:    v_len = sh_vfp;
      default:  v_len = 12'd1;
    endcase
  end

  assign h_last    = (col_cnt == h_len - 12'd1);
  assign v_last    = (row_cnt == v_len - 12'd1);
  assign line_end  = (hstate == ST_FP) && h_last;
  assign frame_end = line_end && (vstate == ST_FP) && v_last;
  // H and V leave IDLE together, so V alone tells us we are idle
  assign start     = (vstate == ST_IDLE) && i_en;
  assign stop      = frame_end && !i_en;
  assign new_frame = start || (frame_end && i_en);

  function automatic logic [2:0] nxt_state(input logic [2:0] s);
    case (s)
      ST_PULSE: nxt_state = ST_BP;
      ST_BP:    nxt_state = ST_ACT;
      ST_ACT:   nxt_state = ST_FP;
      ST_FP:    nxt_state = ST_PULSE;
      default:  nxt_state = ST_IDLE;
    endcase
  endfunction

  // ---------------------------------------------------------------
  // H FSM
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      hstate  <= ST_IDLE;
      col_cnt <= '0;
    end else if (hstate == ST_IDLE) begin
      if (start) hstate <= ST_PULSE;
      col_cnt <= '0;
    end else if (stop) begin
      hstate  <= ST_IDLE;
      col_cnt <= '0;
    end else if (h_last) begin
      hstate  <= nxt_state(hstate);
      col_cnt <= '0;
    end else begin
      col_cnt <= col_cnt + 12'd1;
    end
  end

  // ---------------------------------------------------------------
  // V FSM, stepped on the last HFP cycle of each line
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      vstate  <= ST_IDLE;
      row_cnt <= '0;
    end else if (vstate == ST_IDLE) begin
      if (start) vstate <= ST_PULSE;
      row_cnt <= '0;
    end else if (line_end) begin
      if (stop) begin
        vstate  <= ST_IDLE;
        row_cnt <= '0;
      end else if (v_last) begin
        vstate  <= nxt_state(vstate);
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + 12'd1;
      end
    end
  end

  // ---------------------------------------------------------------
  // shadow configuration and frame counter, loaded on the same edge
  // that enters VPULSE so the new frame runs entirely on new values
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_hres   <= '0;
      sh_vres   <= '0;
      sh_hfp    <= '0;
      sh_hbp    <= '0;
      sh_vfp    <= '0;
      sh_vbp    <= '0;
      sh_hpulse <= '0;
      sh_vpulse <= '0;
      sh_pat    <= 1'b0;
      frame_cnt <= '0;
    end else if (new_frame) begin
      sh_hres   <= {1'b0, i_hres};
      sh_vres   <= {1'b0, i_vres};
      sh_hfp    <= {2'b0, i_hfp};
      sh_hbp    <= {2'b0, i_hbp};
      sh_vfp    <= {2'b0, i_vfp};
      sh_vbp    <= {2'b0, i_vbp};
      sh_hpulse <= {8'b0, i_hpulse};
      sh_vpulse <= {8'b0, i_vpulse};
      sh_pat    <= i_pat_en;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------
  // fetch lookahead
  // o_ren is registered, so the decision made now targets the column
  // that will be active RD_LAT+1 cycles later. With hbp >= RD_LAT the
  // target never lies in a different line, so the current line's V
  // state and row are the right ones to use.
  // ---------------------------------------------------------------
  logic [13:0]    h_off, ahead, act_start, fcol;
  logic           fetch;
  logic [AW2-1:0] row_blk, words_per_row, addr_full;

  always_comb begin
    h_off = '0;
    case (hstate)
      ST_BP:   h_off = {2'b0, sh_hpulse};
      ST_ACT:  h_off = {2'b0, sh_hpulse} + {2'b0, sh_hbp};
      ST_FP:   h_off = {2'b0, sh_hpulse} + {2'b0, sh_hbp} + {2'b0, sh_hres};
      default: h_off = '0;
    endcase
  end

  assign act_start = {2'b0, sh_hpulse} + {2'b0, sh_hbp};
  assign ahead     = {2'b0, col_cnt} + h_off + 14'(RD_LAT + 1);
  assign fcol      = ahead - act_start;
  assign fetch     = (hstate != ST_IDLE) && (vstate == ST_ACT) && !sh_pat &&
                     (ahead >= act_start) && (fcol < {2'b0, sh_hres}) &&
                     ((fcol[11:0] & BW_M) == 12'd0);

  assign row_blk       = AW2'(row_cnt >> LOG_BH);
  assign words_per_row = AW2'(sh_hres >> LOG_BW);
  assign addr_full     = row_blk * words_per_row + AW2'(fcol >> LOG_BW);

  // ---------------------------------------------------------------
  // pixel path (internal timing, registered below)
  // ---------------------------------------------------------------
  logic                  de_int, first_px, fs_int;
  logic [MEM_WIDTH-1:0]  word_cur;
  logic [11:0]           idx;
  logic [DATA_WIDTH-1:0] mem_px, pat_px;
  logic [23:0]           pat24;

  assign de_int   = (hstate == ST_ACT) && (vstate == ST_ACT);
  assign first_px = ((col_cnt & BW_M) == 12'd0);
  // the first pixel of a word comes straight off the bus; the rest of
  // the word's pixels on this line come from the latched copy
  assign word_cur = first_px ? i_rdata : word_q;
  assign idx      = ((row_cnt & BH_M) << LOG_BW) | (col_cnt & BW_M);

  always_comb begin
    mem_px = '0;
    for (int i = 0; i < NPX; i++)
      if (idx == 12'(i)) mem_px = word_cur[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign pat24  = {row_cnt[7:0], col_cnt[7:0], frame_cnt};
  assign pat_px = DATA_WIDTH'(pat24);
  assign fs_int = (vstate == ST_PULSE) && (row_cnt == 12'd0) &&
                  (hstate == ST_PULSE) && (col_cnt == 12'd0);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)
      word_q <= '0;
    else if (de_int && first_px && !sh_pat)
      word_q <= i_rdata;
  end

  // ---------------------------------------------------------------
  // output registers
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ren         <= 1'b0;
      o_raddr       <= '0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_de          <= 1'b0;
      o_data        <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_ren         <= fetch;
      o_raddr       <= fetch ? addr_full[ADDR_WIDTH-1:0] : '0;
      o_hsync       <= (hstate == ST_PULSE);
      o_vsync       <= (vstate == ST_PULSE);
      o_de          <= de_int;
      o_data        <= de_int ? (sh_pat ? pat_px : mem_px) : '0;
      o_frame_start <= fs_int;
    end
  end

endmodule
